// File: rtl/rx_demapper.sv
// Serial frame demapper: hunts for the alignment word, captures payload plus CRC-8,
// optionally ACKs good frames and drains the payload over an AXI-Stream style port.
module rx_demapper #(
  parameter int          PYLD_LEN = 16,
  parameter logic [15:0] FAS_WORD = 16'hF628
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_otn_tx_data,
  output logic       o_otn_tx_ack,
  input  logic       i_arq_en,
  output logic [7:0] o_pyld_data,
  output logic       o_pyld_data_valid,
  input  logic       i_pyld_data_ready,
  output logic       o_crc_err,
  output logic       o_overflow
);

  localparam int NBITS = 8 * PYLD_LEN;
  localparam int BCW   = $clog2(NBITS);
  localparam int IW    = $clog2(PYLD_LEN);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(NBITS - 1);
  localparam logic [IW-1:0]  LAST_BYTE = IW'(PYLD_LEN - 1);

  typedef enum logic [1:0] {
    S_HUNT  = 2'd0,
    S_RECV  = 2'd1,
    S_CRCB  = 2'd2,
    S_CHECK = 2'd3
  } state_t;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  state_t                     r_state;
  logic [15:0]                r_shift;
  logic [BCW-1:0]             r_bitcnt;
  logic [7:0]                 r_crc;
  logic [7:0]                 r_rx_crc;
  logic [PYLD_LEN-1:0][7:0]   r_buf;
  logic                       r_ack;
  logic                       r_err;
  logic                       r_ovf;
  logic                       r_valid;
  logic [IW-1:0]              r_rd_idx;
  logic [7:0]                 r_data;

  logic                       w_fas_hit;
  logic [NBITS-1:0]           w_buf_flat;
  logic                       w_crc_ok;
  logic                       w_start;
  logic                       w_hs;
  logic [IW-1:0]              w_rd_next;

  // The match includes the bit arriving this cycle, so sync is declared one cycle earlier.
  assign w_fas_hit  = ({r_shift[14:0], i_otn_tx_data} == FAS_WORD);
  assign w_buf_flat = r_buf;
  assign w_crc_ok   = (r_crc == r_rx_crc);
  assign w_start    = (r_state == S_CHECK) && (w_crc_ok || !i_arq_en);
  assign w_hs       = r_valid && i_pyld_data_ready;
  assign w_rd_next  = r_rd_idx + 1'b1;

  // Frame FSM: alignment search, payload/CRC capture and status pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_HUNT;
      r_shift  <= 16'h0000;
      r_bitcnt <= '0;
      r_crc    <= 8'h00;
      r_rx_crc <= 8'h00;
      r_buf    <= '0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_shift <= {r_shift[14:0], i_otn_tx_data};
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
      case (r_state)
        S_HUNT: begin
          if (w_fas_hit) begin
            if (r_valid) begin
              r_ovf <= 1'b1;
            end else begin
              r_state  <= S_RECV;
              r_bitcnt <= '0;
              r_crc    <= 8'h00;
            end
          end
        end
        S_RECV: begin
          r_buf <= {w_buf_flat[NBITS-2:0], i_otn_tx_data};
          r_crc <= crc8_step(r_crc, i_otn_tx_data);
          if (r_bitcnt == LAST_BIT) begin
            r_bitcnt <= '0;
            r_state  <= S_CRCB;
          end else begin
            r_bitcnt <= r_bitcnt + 1'b1;
          end
        end
        S_CRCB: begin
          r_rx_crc <= {r_rx_crc[6:0], i_otn_tx_data};
          if (r_bitcnt[2:0] == 3'd7) begin
            r_bitcnt <= '0;
            r_state  <= S_CHECK;
          end else begin
            r_bitcnt <= r_bitcnt + 1'b1;
          end
        end
        S_CHECK: begin
          r_ack   <= w_crc_ok && i_arq_en;
          r_err   <= !w_crc_ok;
          r_state <= S_HUNT;
        end
        default: begin
          r_state <= S_HUNT;
        end
      endcase
    end
  end

  // Payload drain: first byte lands in the CHECK cycle's edge, later bytes advance on handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid  <= 1'b0;
      r_rd_idx <= '0;
      r_data   <= 8'h00;
    end else if (w_start) begin
      r_valid  <= 1'b1;
      r_rd_idx <= '0;
      r_data   <= r_buf[LAST_BYTE];
    end else if (w_hs) begin
      if (r_rd_idx == LAST_BYTE) begin
        r_valid <= 1'b0;
      end else begin
        r_rd_idx <= w_rd_next;
        r_data   <= r_buf[LAST_BYTE - w_rd_next];
      end
    end
  end

  assign o_otn_tx_ack      = r_ack;
  assign o_crc_err         = r_err;
  assign o_overflow        = r_ovf;
  assign o_pyld_data_valid = r_valid;
  assign o_pyld_data       = r_data;

endmodule

// File: tb/tb_rx_demapper.sv
// Scoreboard bench for rx_demapper: frames are modelled at byte level, expected bytes and
// pulse counts are queued at issue time and a negedge monitor checks the DUT against them.
module tb_rx_demapper;
  localparam int          PL  = 16;
  localparam logic [15:0] FAS = 16'hF628;

  typedef byte unsigned pay_t [PL];

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_data;
  logic       tx_ack;
  logic       arq;
  logic [7:0] pdata;
  logic       pvalid;
  logic       pready = 1'b1;
  logic       crc_err;
  logic       ovf;

  rx_demapper #(.PYLD_LEN(PL), .FAS_WORD(FAS)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_otn_tx_data     (tx_data),
    .o_otn_tx_ack      (tx_ack),
    .i_arq_en          (arq),
    .o_pyld_data       (pdata),
    .o_pyld_data_valid (pvalid),
    .i_pyld_data_ready (pready),
    .o_crc_err         (crc_err),
    .o_overflow        (ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ack_cnt = 0, err_cnt = 0, ovf_cnt = 0;
  int exp_ack = 0, exp_err = 0, exp_ovf = 0;
  int rdy_mode = 0;
  byte unsigned exp_q[$];
  int hs_cyc[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: pready = 1'b1;
      1: pready = ~pready;
      2: pready = 1'b0;
      default: pready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (tx_ack) ack_cnt++;
      if (crc_err) err_cnt++;
      if (ovf) ovf_cnt++;
      if (prev_stall) begin
        check("hold_valid", int'(pvalid), 1);
        check("hold_data", int'(pdata), int'(prev_data));
      end
      if (pvalid && pready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got %0d expected none", pdata);
        end else begin
          check("byte", int'(pdata), int'(exp_q.pop_front()));
          hs_cyc.push_back(cyc);
        end
      end
      prev_stall = pvalid && !pready;
      prev_data  = pdata;
    end
  end

  // Byte-wise CRC-8 (poly 0x07, init 0): XOR the byte in, then divide eight times.
  function automatic logic [7:0] crc8(input pay_t p);
    logic [7:0] c;
    c = 8'h00;
    foreach (p[i]) begin
      c = c ^ p[i];
      repeat (8) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    tx_data = 1'b0;
    repeat (n) step();
  endtask

  task automatic expect_frame(input pay_t p, input logic [7:0] c, input logic a);
    logic ok;
    ok = (crc8(p) == c);
    if (!ok) exp_err++;
    if (a && ok) exp_ack++;
    if (ok || !a) foreach (p[i]) exp_q.push_back(p[i]);
  endtask

  // arq carries the final value during FAS and CRC bits, random noise during payload.
  task automatic send_frame(input pay_t p, input logic [7:0] c, input logic a);
    for (int i = 15; i >= 0; i--) begin
      tx_data = FAS[i];
      arq = a;
      step();
    end
    for (int i = 0; i < PL; i++) begin
      for (int b = 7; b >= 0; b--) begin
        tx_data = p[i][b];
        arq = 1'($urandom_range(0, 1));
        step();
      end
    end
    for (int b = 7; b >= 0; b--) begin
      tx_data = c[b];
      arq = a;
      step();
    end
    tx_data = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      step();
      k++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d bytes still expected", exp_q.size());
      exp_q.delete();
    end
    idle(3);
  endtask

  task automatic checkpoint(input string tag);
    check({tag, "_ack_count"}, ack_cnt, exp_ack);
    check({tag, "_err_count"}, err_cnt, exp_err);
    check({tag, "_ovf_count"}, ovf_cnt, exp_ovf);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ack"}, int'(tx_ack), 0);
    check({tag, "_valid"}, int'(pvalid), 0);
    check({tag, "_err"}, int'(crc_err), 0);
    check({tag, "_ovf"}, int'(ovf), 0);
    check({tag, "_data"}, int'(pdata), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pay_t p, p2, z, r;
    logic [7:0] c, cr;
    logic a;

    rst_n = 1'b0;
    tx_data = 1'b0;
    arq = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    step();
    rst_n = 1'b1;
    idle(4);

    for (int i = 0; i < PL; i++) begin
      p[i] = 8'(i);
      z[i] = 8'h00;
    end
    c = crc8(p);

    // Good frame, arq=1, ready always high
    hs_cyc.delete();
    expect_frame(p, c, 1'b1);
    send_frame(p, c, 1'b1);
    @(negedge clk);
    check("check_cycle_ack", int'(tx_ack), 0);
    @(posedge clk);
    @(negedge clk);
    check("ack_latency", int'(tx_ack), 1);
    check("valid_latency", int'(pvalid), 1);
    check("good_err", int'(crc_err), 0);
    wait_drain();
    check("good_byte_count", hs_cyc.size(), PL);
    if (hs_cyc.size() == PL) check("good_back_to_back", hs_cyc[PL-1] - hs_cyc[0], PL - 1);
    checkpoint("good");

    // Corrupted payload, arq=1: error only, nothing delivered
    p2 = p;
    p2[5] = p2[5] ^ 8'h01;
    expect_frame(p2, c, 1'b1);
    send_frame(p2, c, 1'b1);
    idle(20);
    wait_drain();
    checkpoint("bad_arq1");

    // Corrupted payload, arq=0: error and full delivery
    expect_frame(p2, c, 1'b0);
    send_frame(p2, c, 1'b0);
    wait_drain();
    checkpoint("bad_arq0");

    // Good frame with ready toggling
    rdy_mode = 1;
    expect_frame(p, c, 1'b1);
    send_frame(p, c, 1'b1);
    wait_drain();
    rdy_mode = 0;
    idle(2);
    checkpoint("toggle");

    // Back-to-back frame while the drain is held: dropped with overflow
    rdy_mode = 2;
    expect_frame(p, c, 1'b1);
    send_frame(p, c, 1'b1);
    exp_ovf++;
    send_frame(z, crc8(z), 1'b1);
    idle(5);
    check("overflow_seen", ovf_cnt, exp_ovf);
    rdy_mode = 0;
    wait_drain();
    checkpoint("overflow");

    // Payload containing the alignment pattern is not a re-sync
    for (int i = 0; i < PL; i++) r[i] = 8'($urandom_range(0, 255));
    r[3] = 8'hF6;
    r[4] = 8'h28;
    r[PL-1] = 8'h00;
    cr = crc8(r);
    expect_frame(r, cr, 1'b1);
    send_frame(r, cr, 1'b1);
    wait_drain();
    checkpoint("false_fas");

    // Reset during a held drain aborts it
    rdy_mode = 2;
    expect_frame(p, c, 1'b1);
    send_frame(p, c, 1'b1);
    idle(4);
    rst_n = 1'b0;
    #1;
    check("rst_drain_valid", int'(pvalid), 0);
    exp_q.delete();
    step();
    @(negedge clk);
    check_idle_outputs("rst_drain");
    step();
    rst_n = 1'b1;
    rdy_mode = 0;
    idle(30);
    checkpoint("rst_drain");

    // Reset in the middle of payload reception, then a clean frame
    for (int i = 15; i >= 0; i--) begin
      tx_data = FAS[i];
      arq = 1'b1;
      step();
    end
    repeat (40) begin
      tx_data = 1'($urandom_range(0, 1));
      step();
    end
    tx_data = 1'b0;
    rst_n = 1'b0;
    step();
    @(negedge clk);
    check_idle_outputs("rst_recv");
    step();
    rst_n = 1'b1;
    idle(PL * 8 + 20);
    checkpoint("rst_recv_abort");
    expect_frame(p, c, 1'b1);
    send_frame(p, c, 1'b1);
    wait_drain();
    checkpoint("rst_recv_clean");

    // Randomized frames: payload, arq, CRC corruption and ready pattern
    rdy_mode = 3;
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < PL; i++) r[i] = 8'($urandom_range(0, 255));
      r[PL-1] = 8'h00;
      cr = crc8(r);
      if ($urandom_range(0, 2) == 0) cr = cr ^ 8'($urandom_range(1, 255));
      a = 1'($urandom_range(0, 1));
      expect_frame(r, cr, a);
      send_frame(r, cr, a);
      wait_drain();
    end
    rdy_mode = 0;
    idle(4);
    checkpoint("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_demapper.md
RX_DEMAPPER -- requirements
Module: rx_demapper

Interface
REQ-001 Parameter PYLD_LEN, default 16, number of payload bytes per frame (2..64).
REQ-002 Parameter FAS_WORD, default 16'hF628, frame alignment pattern, transmitted MSB first.
REQ-003 i_clk  input  1  single system clock; all logic on rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_otn_tx_data  input  1  serial line data; one bit per i_clk cycle, MSB first, same clock domain.
REQ-006 o_otn_tx_ack  output  1  ACK back to sender; one-cycle pulse per accepted frame.
REQ-007 i_arq_en  input  1  1 = CRC-gated delivery plus ACK; 0 = deliver every frame, no ACK.
REQ-008 o_pyld_data  output  8  payload byte to the UART TX FIFO (AXIS tdata).
REQ-009 o_pyld_data_valid  output  1  AXIS tvalid.
REQ-010 i_pyld_data_ready  input  1  AXIS tready.
REQ-011 o_crc_err  output  1  one-cycle pulse on CRC mismatch.
REQ-012 o_overflow  output  1  one-cycle pulse when a frame is dropped because the buffer is still draining.

Function
REQ-013 Frame format: FAS_WORD (16 bits), PYLD_LEN payload bytes, one CRC-8 byte; no gaps between fields are required.
REQ-014 CRC-8: polynomial 0x07, init 0x00, bit-serial over payload bits only, MSB first; fb = crc[7]^bit; crc = {crc[6:0],1'b0} ^ (fb ? 8'h07 : 8'h00).
REQ-015 A 16-bit shift register shall capture i_otn_tx_data every cycle in every state.
REQ-016 State HUNT: when shift register == FAS_WORD (including the bit sampled this cycle), go to RECV next cycle; bit counter = 0, CRC = 0x00.
REQ-017 HUNT, with FAS match and drain in progress: stay in HUNT, pulse o_overflow, discard the frame, send no ACK.
REQ-018 RECV: sample one bit per cycle into the payload buffer and CRC; after 8*PYLD_LEN bits, go to CRCB.
REQ-019 CRCB: sample 8 bits into the received-CRC register, then go to CHECK.
REQ-020 CHECK (one cycle): compare computed CRC with received CRC, return to HUNT, resume pattern search on the next bit.
REQ-021 CHECK match, i_arq_en=1: o_otn_tx_ack high for exactly the next cycle; start drain.
REQ-022 CHECK mismatch, i_arq_en=1: o_crc_err pulses the next cycle; no ACK; no drain; buffer contents are discarded.
REQ-023 CHECK, i_arq_en=0: always start drain, never ACK; o_crc_err still pulses on mismatch.
REQ-024 i_arq_en is sampled only in CHECK; changes at other times have no effect on the frame in flight.
REQ-025 Drain: present bytes 0..PYLD_LEN-1 in order; a byte advances only on valid&&ready; data and valid stay stable while ready is low.
REQ-026 Drain latency: o_pyld_data_valid rises the cycle after CHECK; valid drops the cycle after the last byte's handshake.
REQ-027 Drain runs concurrently with HUNT; FAS matches found while draining fall under REQ-017.
REQ-028 False FAS inside payload is ignored; the search runs only in HUNT.
REQ-029 There is no loss-of-frame timer; a truncated frame is resolved by the CRC check of the bits that follow.

Reset
REQ-030 While i_rst_n=0: state HUNT, shift register 0, counters 0, CRC 0x00, buffer empty, and o_otn_tx_ack, o_pyld_data_valid, o_crc_err, o_overflow = 0; o_pyld_data = 8'h00.
REQ-031 Reset asserted mid-frame or mid-drain aborts both immediately; no ACK and no further bytes after release; the first FAS search starts the cycle after deassertion.

Verification
REQ-032 Good frame (payload 0x00..0x0F, correct CRC, arq=1, ready=1) -> one ACK pulse; 16 bytes 0x00..0x0F on consecutive cycles; o_crc_err=0.
REQ-033 Same frame with payload bit 0 of byte 5 flipped, arq=1 -> o_crc_err pulse, no ACK, valid never asserts.
REQ-034 Corrupted frame with arq=0 -> o_crc_err pulse, no ACK, all 16 corrupted bytes delivered in order.
REQ-035 Good frame, ready toggling 1/0 each cycle -> 16 bytes in order, no duplicates or drops, data stable while ready=0.
REQ-036 Second frame sent back-to-back while ready=0 holds the drain -> o_overflow pulse, one ACK total, only the first frame's bytes delivered.
REQ-037 Payload containing 0xF6 0x28, then reset pulsed mid-RECV of a later frame -> no false re-sync; after reset outputs are 0 and the next clean frame is ACKed.
